// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel integer clock divider.
package clk_div_pkg;

  // Smallest ratio a channel can run at; requests of 0 or 1 are lifted to this.
  localparam int unsigned MIN_RATIO = 2;

  // Control strobes fanned out from the top to every channel.
  typedef struct packed {
    logic en;
    logic sync;
    logic load;
  } ctrl_t;

  // Lift an illegal ratio (0 or 1) to the minimum legal ratio.
  function automatic int unsigned clamp_ratio(input int unsigned r);
    return (r < MIN_RATIO) ? MIN_RATIO : r;
  endfunction

  // Number of low cycles per period; odd ratios get the extra low cycle.
  function automatic int unsigned low_len(input int unsigned r);
    return r - (r >> 1);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow ratio, pending flag and output flops.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int DEFAULT_RATIO = 8
) (
  input  logic             t_clk,
  input  logic             rst,
  input  ctrl_t            ctrl,
  input  logic [CNT_W-1:0] req_ratio,
  output logic             div_clk,
  output logic             div_stb,
  output logic             ratio_ack
);

  localparam logic [CNT_W-1:0] RATIO_RST = CNT_W'(DEFAULT_RATIO);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] ratio_reg, ratio_next;
  logic [CNT_W-1:0] shadow_reg, shadow_next;
  logic             pend_reg, pend_next;
  logic             clk_reg, clk_next;
  logic             stb_reg, stb_next;
  logic             ack_reg, ack_next;
  logic [CNT_W-1:0] req_clamped;
  logic [CNT_W-1:0] low_next;

  // Next-state for counter, ratios and output levels; sync beats load/wrap beats hold.
  always_comb begin
    req_clamped = CNT_W'(clamp_ratio(32'(req_ratio)));
    cnt_next    = cnt_reg;
    ratio_next  = ratio_reg;
    shadow_next = shadow_reg;
    pend_next   = pend_reg;
    clk_next    = clk_reg;
    stb_next    = 1'b0;
    ack_next    = 1'b0;
    low_next    = '0;

    if (ctrl.sync) begin
      cnt_next = '0;
      clk_next = 1'b0;
      if (ctrl.load) begin
        // Simultaneous load bypasses the shadow and takes effect right away.
        ratio_next  = req_clamped;
        shadow_next = req_clamped;
        pend_next   = 1'b0;
        ack_next    = 1'b1;
      end else if (pend_reg) begin
        ratio_next = shadow_reg;
        pend_next  = 1'b0;
        ack_next   = 1'b1;
      end
    end else begin
      if (ctrl.en) begin
        if (cnt_reg == ratio_reg - CNT_W'(1)) begin
          cnt_next = '0;
          if (pend_reg) begin
            ratio_next = shadow_reg;
            pend_next  = 1'b0;
            ack_next   = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
        low_next = CNT_W'(low_len(32'(ratio_next)));
        clk_next = (cnt_next >= low_next);
        stb_next = (cnt_next == low_next);
      end
      // A load coinciding with a wrap is applied after it, so it waits for the next wrap.
      if (ctrl.load) begin
        shadow_next = req_clamped;
        pend_next   = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset to the default ratio.
  always_ff @(posedge t_clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      ratio_reg  <= RATIO_RST;
      shadow_reg <= RATIO_RST;
      pend_reg   <= 1'b0;
      clk_reg    <= 1'b0;
      stb_reg    <= 1'b0;
      ack_reg    <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      ratio_reg  <= ratio_next;
      shadow_reg <= shadow_next;
      pend_reg   <= pend_next;
      clk_reg    <= clk_next;
      stb_reg    <= stb_next;
      ack_reg    <= ack_next;
    end
  end

  assign div_clk   = clk_reg;
  assign div_stb   = stb_reg;
  assign ratio_ack = ack_reg;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider: NUM_CH independent counter-based channels on t_clk.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 8,
  parameter int DEFAULT_RATIO = 8
) (
  input  logic                    t_clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sync,
  input  logic                    load,
  input  logic [NUM_CH*CNT_W-1:0] div_ratio,
  output logic [NUM_CH-1:0]       div_clk,
  output logic [NUM_CH-1:0]       div_stb,
  output logic [NUM_CH-1:0]       ratio_ack
);

  ctrl_t ctrl;

  // Bundle the common strobes for fan-out to every channel.
  always_comb begin
    ctrl      = '0;
    ctrl.en   = en;
    ctrl.sync = sync;
    ctrl.load = load;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    clk_div_chan #(
      .CNT_W        (CNT_W),
      .DEFAULT_RATIO(DEFAULT_RATIO)
    ) u_chan (
      .t_clk    (t_clk),
      .rst      (rst),
      .ctrl     (ctrl),
      .req_ratio(div_ratio[gi*CNT_W +: CNT_W]),
      .div_clk  (div_clk[gi]),
      .div_stb  (div_stb[gi]),
      .ratio_ack(ratio_ack[gi])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: vector table plus hand-written multi-cycle sequences.
module tb_clk_div_multi;

  logic        t_clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic        load = 1'b0;
  logic [31:0] div_ratio = '0;
  logic [3:0]  div_clk;
  logic [3:0]  div_stb;
  logic [3:0]  ratio_ack;

  int chk_cnt = 0;
  int pass_cnt = 0;

  typedef struct {
    logic        en;
    logic        sync;
    logic        load;
    logic [31:0] ratio;
    logic [3:0]  e_clk;
    logic [3:0]  e_stb;
    logic [3:0]  e_ack;
  } vec_t;

  vec_t tbl [18];

  clk_div_multi #(
    .NUM_CH       (4),
    .CNT_W        (8),
    .DEFAULT_RATIO(8)
  ) dut (
    .t_clk    (t_clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .load     (load),
    .div_ratio(div_ratio),
    .div_clk  (div_clk),
    .div_stb  (div_stb),
    .ratio_ack(ratio_ack)
  );

  always #5 t_clk = ~t_clk;

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic step(input logic e, input logic s, input logic l, input logic [31:0] r);
    en = e; sync = s; load = l; div_ratio = r;
    @(posedge t_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic [3:0] s, input logic [3:0] a);
    chk({tag, "_clk"}, div_clk, c);
    chk({tag, "_stb"}, div_stb, s);
    chk({tag, "_ack"}, ratio_ack, a);
  endtask

  initial begin
    logic [3:0] ec, es;
    logic       hi8, st8, lo, stlo;

    // Load ratio 5 on ch0 (others reload 8) at cnt=2; wrap after the full old period.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h08080805, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 4'hF, 4'h0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 4'h0, 4'h0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 4'h0, 4'h0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 4'h0, 4'h0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 4'h0, 4'hF};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 4'h0, 4'h0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 4'h0, 4'h0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        4'h1, 4'h1, 4'h0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 4'hE, 4'h0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hE, 4'h0, 4'h0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hE, 4'h0, 4'h0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hE, 4'h0, 4'h0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h0,        4'h1, 4'h1, 4'h0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        4'h1, 4'h0, 4'h0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 4'h0, 4'h0};

    // Reset state, then default divide-by-8 on every channel.
    do_reset();
    chk_all("reset", 4'h0, 4'h0, 4'h0);
    for (int k = 1; k <= 24; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      ec = ((k % 8) >= 4) ? 4'hF : 4'h0;
      es = ((k % 8) == 4) ? 4'hF : 4'h0;
      chk_all($sformatf("div8_e%0d", k), ec, es, 4'h0);
    end

    // Table: mid-period load of ratio 5 on channel 0.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].en, tbl[i].sync, tbl[i].load, tbl[i].ratio);
      chk_all($sformatf("tbl%0d", i), tbl[i].e_clk, tbl[i].e_stb, tbl[i].e_ack);
    end

    // Ratios 0 and 1 clamp to 2 on channels 0 and 1 after the wrap.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, (k == 1), 32'h08080100);
      hi8  = ((k % 8) >= 4);
      st8  = ((k % 8) == 4);
      lo   = (k < 8) ? hi8 : ((k > 8) && (k % 2 == 1));
      stlo = (k < 8) ? st8 : ((k > 8) && (k % 2 == 1));
      chk_all($sformatf("clamp_e%0d", k), {hi8, hi8, lo, lo}, {st8, st8, stlo, stlo},
              (k == 8) ? 4'hF : 4'h0);
    end

    // Enable hold while high at cnt=5; resume completes the high phase.
    do_reset();
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int h = 0; h < 10; h++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk_all($sformatf("hold%0d", h), 4'hF, 4'h0, 4'h0);
    end
    for (int k = 6; k <= 12; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      ec = ((k % 8) >= 4) ? 4'hF : 4'h0;
      es = ((k % 8) == 4) ? 4'hF : 4'h0;
      chk_all($sformatf("resume_e%0d", k), ec, es, 4'h0);
    end

    // Ratios 3,6,7,8 drift apart; sync+load 4 realigns all channels.
    do_reset();
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, (k == 1), 32'h08070603);
    chk("drift_ack", ratio_ack, 4'hF);
    for (int r = 1; r <= 5; r++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (r == 3) chk("drift_r3_clk", div_clk, 4'h2);
      if (r == 4) chk("drift_r4_clk", div_clk, 4'hE);
      if (r == 5) chk("drift_r5_clk", div_clk, 4'hF);
    end
    step(1'b1, 1'b1, 1'b1, 32'h04040404);
    chk_all("sync", 4'h0, 4'h0, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      ec = ((k % 4) >= 2) ? 4'hF : 4'h0;
      es = ((k % 4) == 2) ? 4'hF : 4'h0;
      chk_all($sformatf("sync4_e%0d", k), ec, es, 4'h0);
    end

    // Reset mid-period with a pending load discards it.
    do_reset();
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, (k == 3), 32'h05050505);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk_all("midrst", 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      ec = ((k % 8) >= 4) ? 4'hF : 4'h0;
      es = ((k % 8) == 4) ? 4'hF : 4'h0;
      chk_all($sformatf("postrst_e%0d", k), ec, es, 4'h0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel integer clock divider, the successor to the fixed divide-by-8 ripple divider. All channels run in the single `t_clk` domain as counters, with no ripple clocks. Each channel has a runtime-programmable ratio, glitch-free ratio updates at period boundaries, a common enable and a phase-align (sync) control. Outputs are a registered divided-clock level per channel, used as a clock-like signal or enable, plus a one-cycle rising-edge strobe for downstream logic that must stay on `t_clk`.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent divider channels (≥1).
- `CNT_W`, 8: ratio/counter width; legal ratios 2 .. 2^CNT_W−1.
- `DEFAULT_RATIO`, 8: ratio loaded into every channel at reset (divide-by-8 compatible).

Ports:
- `t_clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  common count enable.
- `sync`  in  1  one-cycle request to restart all channels in phase.
- `load`  in  1  one-cycle strobe that captures `div_ratio` into the shadow registers.
- `div_ratio`  in  NUM_CH*CNT_W  per-channel requested ratio; channel c is at bits [c*CNT_W +: CNT_W].
- `div_clk`  out  NUM_CH  divided clock level per channel (registered).
- `div_stb`  out  NUM_CH  one-cycle pulse in the first high cycle of `div_clk`.
- `ratio_ack`  out  NUM_CH  one-cycle pulse when a new ratio becomes active.

## Operation
- Per channel: active ratio R, counter cnt in 0..R−1, shadow ratio S and pending flag P.
- Low length L = R − (R>>1). `div_clk` = (cnt ≥ L): low for L cycles, then high for R>>1 cycles. Even R gives 50 % duty; odd R gives one extra low cycle.
- `div_clk` and `div_stb` are flops updated together with cnt. They are never decoded combinationally from cnt at the output.
- Clamp: a requested ratio of 0 or 1 is treated as 2, both at capture and at direct apply.
- `rst`: cnt=0, R=DEFAULT_RATIO, S=DEFAULT_RATIO, P=0, `div_clk`=0, `div_stb`=0, `ratio_ack`=0.
- `en`=1: cnt increments; at cnt=R−1 it wraps to 0.
  - On wrap with P=1: R←S, P←0, `ratio_ack` pulses in the cycle the new R becomes active, and the counter restarts from 0 with the new R.
- `en`=0: cnt, R and `div_clk` hold their values, and `div_stb` is forced 0. No wrap occurs, so P persists.
- `load` without `sync`: S←clamp(`div_ratio`) and P←1 for all channels. A load in the same cycle as a wrap does not affect that wrap; the wrap uses the old S/P and the new value applies at the next wrap. A second load before the wrap overwrites S (last wins).
- `sync` (overrides `en`): every channel sets cnt=0, `div_clk`=0, `div_stb`=0.
  - Channels with P=1 apply S immediately and pulse `ratio_ack`.
  - `sync` and `load` in the same cycle: clamp(`div_ratio`) is applied directly to R in all channels, P←0, and all `ratio_ack` bits pulse.
- Priority, highest first: `rst` > `sync` > `load`/wrap > `en` hold.

## Timing
- Edges are numbered from the first `t_clk` edge with `en`=1 after reset or sync.
- After edge k, cnt = k mod R.
- `div_clk` rises after edge L and falls after edge R; the period is exactly R cycles.
- R=8: low after edges 0–3, high after edges 4–7.
- R=5: L=3, so 3 low cycles and 2 high cycles.
- `div_stb` is high for exactly one cycle, coincident with the first high cycle of `div_clk`.
- Ratio change latency runs from the load to the next wrap of that channel: at most R_old cycles while `en`=1.
- `ratio_ack` is asserted in the same cycle that cnt=0 under the new R.
- No runt pulses: every high/low phase is a full phase of either the old R or the new R.

## Structure
- Package `clk_div_pkg` holds:
  - a clamp function min-2,
  - the low-length helper L(R).
- Sub-module `clk_div_chan` contains one channel: cnt, R, S, P and the output flops. The top instantiates NUM_CH copies in a generate loop and fans out `t_clk`, `rst`, `en`, `sync` and `load`.

## Test plan
- Reset with `en`=1 and defaults: every `div_clk` gives 4 low, 4 high, period 8; `div_stb` pulses on edges 4, 12, 20; `ratio_ack`=0.
- Load ratio 5 on ch0 mid-period at cnt=2: old period completes (8 cycles), `ratio_ack[0]` pulses at the wrap, then 3 low / 2 high repeating.
- Load ratios 0 and 1 on channels 0 and 1: after the wrap both run at ratio 2, alternating 1 low / 1 high.
- Hold `en`=0 for 10 cycles while `div_clk`=1 and cnt=5: the level and cnt freeze, no `div_stb`; on resume the remaining 2 high cycles complete.
- Channels at ratios 3, 6, 7, 8 drift out of phase; then `sync` with `load` of 4 on all channels: all `div_clk`=0 the next cycle, all `ratio_ack` pulse, all channels run identical 2/2 waveforms in phase.
- Assert `rst` mid-period after a pending load: all outputs are 0 the next cycle, the pending load is discarded and the channel resumes at ratio 8.
